// File: rtl/inference_mac_array_pkg.sv
// Shared types and sizing helpers for the lane-parallel linear-classifier engine.
// INFER_SAT_EN (optional macro) selects saturating arithmetic in the lanes.
package infer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_FLUSH,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam int DEF_NUM_INPUTS  = 784;
  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_LANES       = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ACC_W       = 32;

  function automatic int num_groups(input int classes, input int lanes);
    return (classes + lanes - 1) / lanes;
  endfunction

  // Address width for a given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [63:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

endpackage

// File: rtl/inference_mac_array_if.sv
// Control, memory-port and result bundle of the classifier engine.
// sat_flag exists only when INFER_SAT_EN is defined.
interface inference_mac_array_if import infer_pkg::*; #(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int LANES       = DEF_LANES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W
);
  localparam int NUM_GROUPS = num_groups(NUM_CLASSES, LANES);
  localparam int IN_AW      = addr_w(NUM_INPUTS);
  localparam int W_AW       = addr_w(NUM_GROUPS * NUM_INPUTS);
  localparam int B_AW       = addr_w(NUM_GROUPS);
  localparam int CLS_W      = addr_w(NUM_CLASSES);

  // start is a level request honoured only in IDLE with weights_ready high; done is a
  // one-cycle pulse; every memory returns data exactly one cycle after its address.
  logic                          weights_ready;
  logic                          start;
  logic [IN_AW-1:0]              in_addr;
  logic signed [DATA_W-1:0]      in_data;
  logic [W_AW-1:0]               w_addr;
  logic [LANES*DATA_W-1:0]       w_data;
  logic [B_AW-1:0]               b_addr;
  logic [LANES*ACC_W-1:0]        b_data;
  logic                          busy;
  logic                          done;
  logic [CLS_W-1:0]              pred_class;
  logic signed [ACC_W-1:0]       pred_score;
  logic [NUM_CLASSES*ACC_W-1:0]  scores;
  state_t                        dbg_state;
`ifdef INFER_SAT_EN
  logic                          sat_flag;
`endif

  modport master (
    output weights_ready, start, in_data, w_data, b_data,
    input  in_addr, w_addr, b_addr, busy, done, pred_class, pred_score, scores, dbg_state
`ifdef INFER_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  weights_ready, start, in_data, w_data, b_data,
    output in_addr, w_addr, b_addr, busy, done, pred_class, pred_score, scores, dbg_state
`ifdef INFER_SAT_EN
    , output sat_flag
`endif
  );

endinterface

// File: rtl/inference_mac_array_lane.sv
// One class lane: registered signed product, accumulator, and the bias-added score.
// With INFER_SAT_EN both additions clamp to the ACC_W signed range and report it.
module infer_mac_lane import infer_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_mul_en,
  input  logic                     i_acc_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic signed [ACC_W-1:0]  i_bias,
  output logic signed [ACC_W-1:0]  o_score
`ifdef INFER_SAT_EN
  , output logic                   o_sat
`endif
);
  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] r_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_biased;
  logic signed [ACC_W-1:0]  w_acc_nxt;

  assign w_prod_ext = ACC_W'(r_prod);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_biased   = r_acc + i_bias;

`ifdef INFER_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  logic r_sat;
  logic w_sum_ovf;
  logic w_bias_ovf;

  // Overflow only when both operands share a sign the result does not.
  assign w_sum_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_bias_ovf = (r_acc[ACC_W-1] == i_bias[ACC_W-1]) && (w_biased[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_acc_nxt  = w_sum_ovf ? (r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_sum;
  assign o_score    = w_bias_ovf ? (r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_biased;
  assign o_sat      = r_sat | w_bias_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (i_clear) begin
      r_sat <= 1'b0;
    end else if (i_acc_en && w_sum_ovf) begin
      r_sat <= 1'b1;
    end
  end
`else
  assign w_acc_nxt = w_sum;
  assign o_score   = w_biased;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_acc  <= '0;
    end else if (i_clear) begin
      r_prod <= '0;
      r_acc  <= '0;
    end else begin
      if (i_mul_en) r_prod <= PROD_W'(i_x) * PROD_W'(i_w);
      if (i_acc_en) r_acc  <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/inference_mac_array.sv
// Softmax-regression inference engine: LANES class dot-products per pass, bias add, argmax.
// Define INFER_SAT_EN for saturating arithmetic and the sticky sat_flag output.
module inference_mac_array import infer_pkg::*; #(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int LANES       = DEF_LANES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W
) (
  input logic                  clk,
  input logic                  rst_n,
  inference_mac_array_if.slave bus
);
  localparam int NUM_GROUPS = num_groups(NUM_CLASSES, LANES);
  localparam int IN_AW      = addr_w(NUM_INPUTS);
  localparam int W_AW       = addr_w(NUM_GROUPS * NUM_INPUTS);
  localparam int B_AW       = addr_w(NUM_GROUPS);
  localparam int CLS_W      = addr_w(NUM_CLASSES);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  state_t                  r_state, w_state_nxt;
  logic                    r_busy, r_done;
  logic [IN_AW-1:0]        r_in_addr;
  logic [W_AW-1:0]         r_w_addr, r_w_base;
  logic [B_AW-1:0]         r_g;
  logic [1:0]              r_flush_cnt;
  logic                    r_v_data, r_v_prod;
  logic signed [ACC_W-1:0] r_max, w_max_nxt, r_pred_score;
  logic [CLS_W-1:0]        r_max_idx, w_idx_nxt, r_pred_class;
  logic signed [ACC_W-1:0] r_work   [NUM_CLASSES];
  logic signed [ACC_W-1:0] r_scores [NUM_CLASSES];
  logic signed [ACC_W-1:0] w_score  [LANES];
  logic [CLS_W-1:0]        w_lane_cls [LANES];
  logic [LANES-1:0]        w_lane_live;
  logic w_accept, w_lane_clear, w_mac_step, w_update, w_finish;
  logic w_last_in, w_last_flush, w_last_group;

  assign w_last_in    = (r_in_addr == IN_AW'(NUM_INPUTS - 1));
  assign w_last_flush = (r_flush_cnt == 2'd2);
  assign w_last_group = (r_g == B_AW'(NUM_GROUPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_MAC;
      S_MAC:    if (w_last_in) w_state_nxt = S_FLUSH;
      S_FLUSH:  if (w_last_flush) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = w_last_group ? S_DONE : S_LOAD;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept     = 1'b0;
    w_lane_clear = 1'b0;
    w_mac_step   = 1'b0;
    w_update     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE:   w_accept     = bus.start && bus.weights_ready;
      S_LOAD:   w_lane_clear = 1'b1;
      S_MAC:    w_mac_step   = !w_last_in;
      S_UPDATE: w_update     = 1'b1;
      S_DONE:   w_finish     = 1'b1;
      default:  ;
    endcase
  end

  // Lanes past NUM_CLASSES in the last group are neither stored nor compared.
  always_comb begin
    w_max_nxt = r_max;
    w_idx_nxt = r_max_idx;
    for (int l = 0; l < LANES; l++) begin
      if (w_lane_live[l] && (w_score[l] > w_max_nxt)) begin
        w_max_nxt = w_score[l];
        w_idx_nxt = w_lane_cls[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_in_addr    <= '0;
      r_w_addr     <= '0;
      r_w_base     <= '0;
      r_g          <= '0;
      r_flush_cnt  <= '0;
      r_v_data     <= 1'b0;
      r_v_prod     <= 1'b0;
      r_max        <= ACC_MIN;
      r_max_idx    <= '0;
      r_pred_class <= '0;
      r_pred_score <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        r_work[c]   <= '0;
        r_scores[c] <= '0;
      end
    end else begin
      r_done   <= 1'b0;
      r_v_data <= (r_state == S_MAC);
      r_v_prod <= w_lane_clear ? 1'b0 : r_v_data;
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_g       <= '0;
        r_w_base  <= '0;
        r_max     <= ACC_MIN;
        r_max_idx <= '0;
      end
      if (w_lane_clear) begin
        r_in_addr   <= '0;
        r_w_addr    <= r_w_base;
        r_flush_cnt <= '0;
      end
      if (w_mac_step) begin
        r_in_addr <= r_in_addr + IN_AW'(1);
        r_w_addr  <= r_w_addr + W_AW'(1);
      end
      if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + 2'd1;
      if (w_update) begin
        r_max     <= w_max_nxt;
        r_max_idx <= w_idx_nxt;
        for (int l = 0; l < LANES; l++) begin
          if (w_lane_live[l]) r_work[w_lane_cls[l]] <= w_score[l];
        end
        if (!w_last_group) begin
          r_g      <= r_g + B_AW'(1);
          r_w_base <= r_w_base + W_AW'(NUM_INPUTS);
        end
      end
      if (w_finish) begin
        r_pred_class <= r_max_idx;
        r_pred_score <= r_max;
        r_done       <= 1'b1;
        r_busy       <= 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) r_scores[c] <= r_work[c];
      end
    end
  end

`ifdef INFER_SAT_EN
  logic [LANES-1:0] w_lane_sat;
  logic             r_sat_any, r_sat_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_any  <= 1'b0;
      r_sat_flag <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sat_any  <= 1'b0;
        r_sat_flag <= 1'b0;
      end else if (w_update && |(w_lane_sat & w_lane_live)) begin
        r_sat_any <= 1'b1;
      end
      if (w_finish) r_sat_flag <= r_sat_any;
    end
  end

  assign bus.sat_flag = r_sat_flag;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_live[l] = ((int'(r_g) * LANES + l) < NUM_CLASSES);
    assign w_lane_cls[l]  = CLS_W'(int'(r_g) * LANES + l);

    infer_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_lane_clear),
      .i_mul_en (r_v_data),
      .i_acc_en (r_v_prod),
      .i_x      (bus.in_data),
      .i_w      (bus.w_data[l*DATA_W +: DATA_W]),
      .i_bias   (bus.b_data[l*ACC_W +: ACC_W]),
      .o_score  (w_score[l])
`ifdef INFER_SAT_EN
      , .o_sat  (w_lane_sat[l])
`endif
    );
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_score_out
    assign bus.scores[c*ACC_W +: ACC_W] = r_scores[c];
  end

  assign bus.in_addr    = r_in_addr;
  assign bus.w_addr     = r_w_addr;
  assign bus.b_addr     = r_g;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pred_class = r_pred_class;
  assign bus.pred_score = r_pred_score;
  assign bus.dbg_state  = r_state;

endmodule
